fifo_write_arbiter: RTL

//  Round-robin arbiter that shares the single write port of sync_FIFO_buffer between
//  N_REQ producers. Grants one owner at a time for bursts of up to MAX_BURST words.

---
 rtl/fifo_write_arbiter_if.sv | 50 +++++
 rtl/fifo_write_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter_if.sv
// Producer/FIFO-side bundle of the round-robin FIFO write arbiter.
// lock_i is present only when FIFO_ARB_LOCK_EN is defined.
interface fifo_write_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]            req_i;
    logic [N_REQ*DATA_WIDTH-1:0] data_i;
`ifdef FIFO_ARB_LOCK_EN
    logic [N_REQ-1:0]            lock_i;
`endif
    logic [N_REQ-1:0]            accept_o;
    logic [N_REQ-1:0]            gnt_o;
    logic [ID_W-1:0]             gnt_id_o;
    logic                        fifo_full_i;
    logic                        fifo_write_o;
    logic [DATA_WIDTH-1:0]       fifo_wr_data_o;

    // Arbiter side
    modport slave (
`ifdef FIFO_ARB_LOCK_EN
        input  lock_i,
`endif
        input  req_i,
        input  data_i,
        input  fifo_full_i,
        output accept_o,
        output gnt_o,
        output gnt_id_o,
        output fifo_write_o,
        output fifo_wr_data_o
    );

    // Producers plus FIFO side
    modport master (
`ifdef FIFO_ARB_LOCK_EN
        output lock_i,
`endif
        output req_i,
        output data_i,
        output fifo_full_i,
        input  accept_o,
        input  gnt_o,
        input  gnt_id_o,
        input  fifo_write_o,
        input  fifo_wr_data_o
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers in bursts
// of up to MAX_BURST words. Define FIFO_ARB_LOCK_EN to enable per-owner burst locking.
module fifo_write_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    fifo_write_arbiter_if.slave  bus
);
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   rrPtr_q, rrPtr_d;
    logic [CNT_W-1:0]  burstCnt_q, burstCnt_d;

    logic [ID_W-1:0]       winHi, winLo, winner;
    logic                  foundHi, foundLo;
    logic [N_REQ-1:0]      ownerOneHot;
    logic                  ownerReq;
    logic                  ownerLock;
    logic [DATA_WIDTH-1:0] ownerData;
    logic                  limitHit;
    logic                  writeEn;
    logic                  releaseOwn;

    // Round-robin pick: lowest requester at or above rrPtr, else lowest overall.
    always_comb begin
        winHi   = '0;
        winLo   = '0;
        foundHi = 1'b0;
        foundLo = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (bus.req_i[k] && !foundLo) begin
                foundLo = 1'b1;
                winLo   = ID_W'(k);
            end
            if (bus.req_i[k] && !foundHi && (ID_W'(k) >= rrPtr_q)) begin
                foundHi = 1'b1;
                winHi   = ID_W'(k);
            end
        end
        winner = foundHi ? winHi : winLo;
    end

    always_comb begin
        ownerOneHot = '0;
        ownerReq    = 1'b0;
        ownerLock   = 1'b0;
        ownerData   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (owner_q == ID_W'(k)) begin
                ownerOneHot[k] = 1'b1;
                ownerReq       = bus.req_i[k];
                ownerData      = bus.data_i[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef FIFO_ARB_LOCK_EN
                ownerLock      = bus.lock_i[k];
`endif
            end
        end
    end

    // True when the write about to be accepted reaches (or passes) the burst limit.
    assign limitHit = ((CNT_W+1)'(burstCnt_q) + (CNT_W+1)'(1)) >= (CNT_W+1)'(MAX_BURST);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rrPtr_d    = rrPtr_q;
        burstCnt_d = burstCnt_q;
        writeEn    = 1'b0;
        releaseOwn = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req_i) begin
                    owner_d    = winner;
                    burstCnt_d = '0;
                    state_d    = OWN;
                end
            end
            OWN: begin
                writeEn = ownerReq & ~bus.fifo_full_i;
                if (!ownerReq) begin
                    releaseOwn = 1'b1;
                end else if (writeEn) begin
                    // Saturate so a locked owner keeps the limit armed for when lock falls.
                    burstCnt_d = limitHit ? CNT_W'(MAX_BURST) : burstCnt_q + CNT_W'(1);
                    if (limitHit && !ownerLock) begin
                        releaseOwn = 1'b1;
                    end
                end
                if (releaseOwn) begin
                    state_d    = IDLE;
                    burstCnt_d = '0;
                    rrPtr_d    = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rrPtr_q    <= '0;
            burstCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rrPtr_q    <= rrPtr_d;
            burstCnt_q <= burstCnt_d;
        end
    end

    assign bus.gnt_o          = (state_q == OWN) ? ownerOneHot : '0;
    assign bus.gnt_id_o       = (state_q == OWN) ? owner_q : '0;
    assign bus.accept_o       = writeEn ? ownerOneHot : '0;
    assign bus.fifo_write_o   = writeEn;
    assign bus.fifo_wr_data_o = (state_q == OWN) ? ownerData : '0;

endmodule
